// File: rtl/conv_out_serializer.sv
// conv_out_serializer
//   Consumer end of the conv output-channel result bus. When every channel
//   reports valid in the same cycle the block captures the whole vector,
//   requantizes all accumulators in parallel (round half up, arithmetic
//   shift, ReLU, saturate to unsigned DATA_W) and then streams one channel
//   per beat toward the pooling/writeback stage.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   valid_in  : per-channel result valid (bit c = channel c)
//   acc_in    : packed accumulators, channel 0 in the MSBs
//   in_ready  : a vector can be captured this cycle
//   m_valid   : output beat valid
//   m_ready   : downstream accepts the beat
//   m_data    : requantized activation
//   m_ch      : channel index of the current beat
//   m_last    : current beat is channel OUT_CH-1
//   overrun   : sticky, a vector arrived while the block could not take it
//   partial   : sticky, valid_in was neither all-zero nor all-one
//
// Handshake: a beat transfers on a rising edge where m_valid & m_ready are
// both high. While m_valid is high and m_ready is low, m_data, m_ch and
// m_last hold their values. m_valid never drops before its beat transfers
// (except on reset).
module conv_out_serializer #(
  parameter int ACC_W  = 32,
  parameter int OUT_CH = 8,
  parameter int DATA_W = 8,
  parameter int SHIFT  = 8,
  parameter int CH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OUT_CH-1:0]       valid_in,
  input  logic [OUT_CH*ACC_W-1:0] acc_in,
  output logic                    in_ready,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic [CH_W-1:0]         m_ch,
  output logic                    m_last,
  output logic                    overrun,
  output logic                    partial
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(OUT_CH - 1);

  // Rounding constant 2^(SHIFT-1); zero when there is no shift at all.
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // Largest representable activation, 2^DATA_W-1, in the widened domain.
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   idx;
  logic [DATA_W-1:0] data_buf [OUT_CH];
  logic              all_valid;
  logic              any_valid;
  logic              beat_done;
  logic              capture;

  // Requantize one accumulator. One extra bit of headroom keeps the
  // rounding add from wrapping at the positive extreme.
  function automatic logic [DATA_W-1:0] requant(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] r;
    t = $signed({acc[ACC_W-1], acc}) + RND;
    r = t >>> SHIFT;
    if (r[ACC_W]) begin
      requant = '0;
    end else if (r > MAXV) begin
      requant = '1;
    end else begin
      requant = r[DATA_W-1:0];
    end
  endfunction

  assign all_valid = &valid_in;
  assign any_valid = |valid_in;
  assign beat_done = m_valid & m_ready;
  assign capture   = all_valid & in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A capture on the last handshake keeps the block in
  // DRAIN so consecutive vectors stream without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (capture) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (beat_done && m_last) state_nxt = capture ? DRAIN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    m_valid  = (state == DRAIN);
    m_ch     = idx;
    m_data   = data_buf[idx];
    m_last   = (state == DRAIN) && (idx == LAST_IDX);
    in_ready = (state == IDLE) | (m_valid & m_ready & m_last);
  end

  // Beat index and requantized vector buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      for (int c = 0; c < OUT_CH; c++) data_buf[c] <= '0;
    end else if (capture) begin
      idx <= '0;
      for (int c = 0; c < OUT_CH; c++) begin
        data_buf[c] <= requant(acc_in[ACC_W*(OUT_CH-c)-1 -: ACC_W]);
      end
    end else if (beat_done && !m_last) begin
      idx <= idx + CH_W'(1);
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      partial <= 1'b0;
    end else begin
      if (any_valid && !in_ready)  overrun <= 1'b1;
      if (any_valid && !all_valid) partial <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_out_serializer.sv
module tb_conv_out_serializer;

  localparam int ACC_W  = 32;
  localparam int OUT_CH = 8;
  localparam int DATA_W = 8;
  localparam int SHIFT  = 8;
  localparam int CH_W   = 3;
  localparam int EW     = DATA_W + CH_W + 1;

  // ---------------- clock / reset ----------------
  logic                    clk = 1'b0;
  logic                    rst;
  logic [OUT_CH-1:0]       valid_in;
  logic [OUT_CH*ACC_W-1:0] acc_in;
  logic                    in_ready;
  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_data;
  logic [CH_W-1:0]         m_ch;
  logic                    m_last;
  logic                    overrun;
  logic                    partial;

  always #5 clk = ~clk;

  conv_out_serializer #(
    .ACC_W(ACC_W), .OUT_CH(OUT_CH), .DATA_W(DATA_W), .SHIFT(SHIFT), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .acc_in(acc_in),
    .in_ready(in_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
    .overrun(overrun), .partial(partial)
  );

  // ---------------- vectors and hand-computed results ----------------
  // Vector A: round/shift by 8, ReLU, saturation at both ends.
  logic [ACC_W-1:0]  vec_a [OUT_CH] = '{32'd4736, -32'sd5000, 32'h7FFF_FFFF,
                                        32'd76800, 32'd255, 32'd127, 32'd256, 32'd0};
  logic [DATA_W-1:0] exp_a [OUT_CH] = '{8'd19, 8'd0, 8'd255, 8'd255,
                                        8'd1, 8'd0, 8'd1, 8'd0};
  // Vector B: rounding boundaries around 0.5 and the 255/256 edge.
  logic [ACC_W-1:0]  vec_b [OUT_CH] = '{32'd128, 32'd383, 32'd384, -32'sd128,
                                        -32'sd129, 32'd65407, 32'd65408, 32'd1000};
  logic [DATA_W-1:0] exp_b [OUT_CH] = '{8'd1, 8'd1, 8'd2, 8'd0,
                                        8'd0, 8'd255, 8'd255, 8'd4};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every transferred beat is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got data=%0d ch=%0d last=%0b expected no beat",
                 m_data, m_ch, m_last);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({m_data, m_ch, m_last} !== e) begin
          n_fail++;
          $display("FAIL beat: got data=%0d ch=%0d last=%0b expected data=%0d ch=%0d last=%0b",
                   m_data, m_ch, m_last, e[EW-1 -: DATA_W], e[CH_W:1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks are entered and left at posedge+1.
  task automatic load_vec(input logic [ACC_W-1:0] v [OUT_CH]);
    for (int c = 0; c < OUT_CH; c++) acc_in[ACC_W*(OUT_CH-c)-1 -: ACC_W] = v[c];
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] e [OUT_CH]);
    for (int c = 0; c < OUT_CH; c++) exp_q.push_back({e[c], CH_W'(c), c == OUT_CH - 1});
  endtask

  // Present an all-valid vector for one cycle; returns in the first beat cycle.
  task automatic capture(input logic [ACC_W-1:0] v [OUT_CH],
                         input logic [DATA_W-1:0] e [OUT_CH]);
    load_vec(v);
    valid_in = '1;
    push_exp(e);
    @(posedge clk); #1;
    valid_in = '0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    n_tests++;
    if (k == 40) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst      = 1'b1;
    valid_in = '0;
    acc_in   = '0;
    m_ready  = 1'b1;
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data,  0);
    check("rst_m_ch",    m_ch,    0);
    check("rst_m_last",  m_last,  0);
    check("rst_overrun", overrun, 0);
    check("rst_partial", partial, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1) Basic vector, m_ready held high.
    check("t1_in_ready", in_ready, 1);
    capture(vec_a, exp_a);
    check("t1_lat_valid", m_valid, 1);
    check("t1_lat_ch", m_ch, 0);
    wait_drain("t1");
    check("t1_idle", m_valid, 0);

    // 2) Backpressure on beat 2 for three cycles.
    capture(vec_a, exp_a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_valid", m_valid, 1);
      check("t2_hold_data",  m_data,  255);
      check("t2_hold_ch",    m_ch,    2);
      check("t2_hold_last",  m_last,  0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain("t2");

    // 3) Next vector offered on the last handshake: no bubble.
    capture(vec_a, exp_a);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("t3_last_beat", m_last, 1);
    check("t3_in_ready", in_ready, 1);
    capture(vec_b, exp_b);
    check("t3_b2b_valid", m_valid, 1);
    check("t3_b2b_ch", m_ch, 0);
    check("t3_b2b_data", m_data, 1);
    wait_drain("t3");
    check("t3_idle", m_valid, 0);
    check("t3_no_overrun", overrun, 0);
    check("t3_no_partial", partial, 0);

    // 4) Full vector arrives mid-drain: overrun, current drain untouched.
    capture(vec_a, exp_a);
    repeat (3) begin
      @(posedge clk); #1;
    end
    load_vec(vec_b);
    valid_in = '1;
    check("t4_in_ready", in_ready, 0);
    @(posedge clk); #1;
    valid_in = '0;
    check("t4_overrun", overrun, 1);
    check("t4_ch_after", m_ch, 4);
    wait_drain("t4");
    check("t4_idle", m_valid, 0);
    check("t4_overrun_sticky", overrun, 1);

    // 5) Partial vector in IDLE is never captured.
    load_vec(vec_b);
    valid_in = 8'h0F;
    @(posedge clk); #1;
    valid_in = '0;
    check("t5_partial", partial, 1);
    check("t5_no_capture", m_valid, 0);
    @(posedge clk); #1;
    check("t5_still_idle", m_valid, 0);

    // 6) Reset during beat 4 discards the rest of the vector.
    capture(vec_a, exp_a);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t6_pre_ch", m_ch, 4);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", m_valid, 0);
    // Beats 0..3 were transferred; the pending tail is dropped with reset.
    check("t6_discarded", exp_q.size(), 4);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_in_ready", in_ready, 1);
    check("t6_overrun_clr", overrun, 0);
    check("t6_partial_clr", partial, 0);
    capture(vec_b, exp_b);
    check("t6_restart_ch", m_ch, 0);
    check("t6_restart_data", m_data, 1);
    wait_drain("t6");
    check("t6_idle", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
